axi4lite_tohost_console: RTL and testbench

//   Byte-stream to tohost bridge: buffers console characters from a valid/ready source in a small FIFO.

---
 rtl/axi4lite_tohost_console_if.sv | 61 ++++++
 rtl/axi4lite_tohost_console.sv | 185 ++++++++++++++++++
 tb/tb_axi4lite_tohost_console.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_tohost_console_if.sv
// AXI4-Lite bus bundle shared by the tohost console master and its slave.
// Clock and reset travel with the bundle so either side can reach them.
interface axi4lite #(
    parameter int ALEN = 32,
    parameter int DLEN = 64
) (
    input logic aclk,
    input logic aresetn
);
    logic              awvalid;
    logic              awready;
    logic [ALEN-1:0]   awaddr;
    logic [2:0]        awprot;

    logic              wvalid;
    logic              wready;
    logic [DLEN-1:0]   wdata;
    logic [DLEN/8-1:0] wstrb;

    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;

    logic              arvalid;
    logic              arready;
    logic [ALEN-1:0]   araddr;
    logic [2:0]        arprot;

    logic              rvalid;
    logic              rready;
    logic [DLEN-1:0]   rdata;
    logic [1:0]        rresp;

    modport master (
        input  aclk, aresetn,
        output awvalid, awaddr, awprot,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arprot,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

    modport slave (
        input  aclk, aresetn,
        input  awvalid, awaddr, awprot,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arprot,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );
endinterface

// File: rtl/axi4lite_tohost_console.sv
// Console byte stream to tohost bridge.
// Characters are queued in a small FIFO and drained one AXI4-Lite write at a
// time using the blocking char-device encoding (device 1, cmd 1, payload byte).
// Non-OKAY write responses are counted in a saturating counter.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no write in flight; pops the FIFO head when one is available
// SEND  | AW and W offered; each dropped independently once accepted
// RESP  | both accepted; waiting for the B response
module axi4lite_tohost_console #(
    parameter int              ALEN        = 32,
    parameter logic [ALEN-1:0] TOHOST_ADDR = '0,
    parameter int              FIFO_DEPTH  = 8,
    parameter int              ERR_W       = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             char_valid,
    input  logic [7:0]       char_data,
    output logic             char_ready,
    output logic             busy,
    output logic [ERR_W-1:0] err_count,
    axi4lite.master          bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    logic [7:0]       wchar;
    logic             aw_done;
    logic             w_done;
    logic             aw_hs;
    logic             w_hs;
    logic             b_hs;
    logic             send_done;

    // Read side of the bus and the bundled clock/reset are not used by a write-only master.
    logic             unused_bus;
    assign unused_bus = ^{bus.aclk, bus.aresetn, bus.arready, bus.rvalid,
                          bus.rdata, bus.rresp};

    assign char_ready = (count != CNT_W'(FIFO_DEPTH));
    assign push       = char_valid && char_ready;
    assign pop        = (state == ST_IDLE) && (count != '0);
    assign busy       = (state != ST_IDLE) || (count != '0);

    assign aw_hs      = bus.awvalid && bus.awready;
    assign w_hs       = bus.wvalid && bus.wready;
    assign b_hs       = bus.bvalid && bus.bready;
    assign send_done  = (aw_done || aw_hs) && (w_done || w_hs);

    // Payloads depend only on the latched char, so they stay stable while valid is high.
    assign bus.awaddr  = TOHOST_ADDR;
    assign bus.awprot  = 3'b000;
    assign bus.wdata   = {8'h01, 8'h01, 40'h0, wchar};
    assign bus.wstrb   = '1;
    assign bus.arvalid = 1'b0;
    assign bus.araddr  = '0;
    assign bus.arprot  = 3'b000;
    assign bus.rready  = 1'b0;

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= char_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally for a power-of-two depth.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Write FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (send_done) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.bvalid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write FSM outputs; AW and W valids are retired independently.
    always_comb begin
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        case (state)
            ST_SEND: begin
                bus.awvalid = !aw_done;
                bus.wvalid  = !w_done;
            end
            ST_RESP: begin
                bus.bready  = 1'b1;
            end
            default: begin
                bus.awvalid = 1'b0;
            end
        endcase
    end

    // Latches the popped char and tracks which address/data beats have been accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wchar   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (pop) begin
            wchar   <= fifo_mem[rd_ptr];
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == ST_SEND) begin
            if (aw_hs) begin
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                w_done  <= 1'b1;
            end
        end
    end

    // Saturating count of error responses (anything other than OKAY).
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_count <= '0;
        end else if (b_hs && (bus.bresp != 2'b00) && (err_count != '1)) begin
            err_count <= err_count + ERR_W'(1);
        end
    end
endmodule

// File: tb/tb_axi4lite_tohost_console.sv
// Bench for the tohost console bridge: an AXI4-Lite slave model with
// controllable readies and responses, a queue-based reference of expected
// characters, and a saturating error-count model.  A second DUT with a 2-bit
// error counter runs in lockstep to exercise saturation.
module tb_axi4lite_tohost_console;
    localparam int          FD    = 8;
    localparam logic [31:0] TADDR = 32'h4000_1000;

    logic        aclk;
    logic        aresetn;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        busy;
    logic [15:0] err_count;
    logic        char_ready2;
    logic        busy2;
    logic [1:0]  err_count2;

    axi4lite #(.ALEN(32), .DLEN(64)) bus  (.aclk(aclk), .aresetn(aresetn));
    axi4lite #(.ALEN(32), .DLEN(64)) bus2 (.aclk(aclk), .aresetn(aresetn));

    axi4lite_tohost_console #(.ALEN(32), .TOHOST_ADDR(TADDR), .FIFO_DEPTH(FD), .ERR_W(16)) dut (
        .aclk(aclk), .aresetn(aresetn), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .busy(busy), .err_count(err_count), .bus(bus));

    axi4lite_tohost_console #(.ALEN(32), .TOHOST_ADDR(TADDR), .FIFO_DEPTH(FD), .ERR_W(2)) dut2 (
        .aclk(aclk), .aresetn(aresetn), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready2), .busy(busy2), .err_count(err_count2), .bus(bus2));

    assign bus2.awready = bus.awready;
    assign bus2.wready  = bus.wready;
    assign bus2.bvalid  = bus.bvalid;
    assign bus2.bresp   = bus.bresp;
    assign bus2.arready = bus.arready;
    assign bus2.rvalid  = bus.rvalid;
    assign bus2.rdata   = bus.rdata;
    assign bus2.rresp   = bus.rresp;

    typedef struct {
        logic [7:0]  ch;
        logic [1:0]  resp;
        logic [15:0] e16;
        logic [1:0]  e2;
    } vec_t;
    vec_t vt [10];

    int n_vec = 0;
    int n_err = 0;

    // slave model state
    bit         hold_aw, hold_w, rand_ready, rand_resp;
    bit         hs_aw, hs_w, hs_b, got_aw, got_w;
    logic [1:0] resp_q [$];

    // reference model
    logic [7:0]  exp_q [$];
    int          model_err;
    int          outst;
    int          aw_cnt, w_cnt, b_cnt, push_cnt;
    bit          prev_aw_pend, prev_w_pend;
    logic [63:0] prev_wdata;
    logic [63:0] exp_w;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic check_err(input string tag);
        check({tag, "_err16"}, err_count, sat(model_err, 65535));
        check({tag, "_err2"}, err_count2, sat(model_err, 3));
    endtask

    task automatic wait_b(input int target, input int budget);
        int k = 0;
        while (b_cnt < target && k < budget) begin
            @(posedge aclk);
            k++;
        end
        #1;
        check("b_wait", (b_cnt >= target), 1);
    endtask

    // Slave driver: responds after each edge using handshakes seen on the previous negedge.
    initial begin
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
        got_aw = 0; got_w = 0;
        forever begin
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                got_aw = 0; got_w = 0;
                bus.bvalid = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
            end else begin
                if (hs_aw) got_aw = 1;
                if (hs_w)  got_w  = 1;
                if (hs_b) begin
                    bus.bvalid = 1'b0;
                    got_aw = 0;
                    got_w  = 0;
                end
                if (got_aw && got_w && !bus.bvalid) begin
                    bus.bvalid = 1'b1;
                    if (resp_q.size() > 0) bus.bresp = resp_q.pop_front();
                    else if (rand_resp)    bus.bresp = 2'($urandom_range(0, 3));
                    else                   bus.bresp = 2'b00;
                end
                bus.awready = !hold_aw && (!rand_ready || ($urandom_range(0, 1) == 1));
                bus.wready  = !hold_w  && (!rand_ready || ($urandom_range(0, 1) == 1));
            end
        end
    end

    // Monitor and reference model, sampled mid-cycle.
    initial begin
        model_err = 0; outst = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; push_cnt = 0;
        hs_aw = 0; hs_w = 0; hs_b = 0; prev_aw_pend = 0; prev_w_pend = 0; prev_wdata = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                hs_aw = 0; hs_w = 0; hs_b = 0;
                exp_q.delete();
                outst = 0; model_err = 0;
                prev_aw_pend = 0; prev_w_pend = 0;
            end else begin
                hs_aw = bus.awvalid && bus.awready;
                hs_w  = bus.wvalid && bus.wready;
                hs_b  = bus.bvalid && bus.bready;
                if (prev_aw_pend) check("aw_held", {bus.awvalid, bus.awaddr}, {1'b1, TADDR});
                if (prev_w_pend) begin
                    check("w_held_valid", bus.wvalid, 1);
                    check("w_held_data", bus.wdata, prev_wdata);
                end
                if (hs_aw) begin
                    check("awaddr", bus.awaddr, TADDR);
                    check("outstanding", outst, 0);
                    outst++;
                    aw_cnt++;
                end
                if (hs_w) begin
                    if (exp_q.size() > 0) exp_w = {16'h0101, 40'h0, exp_q.pop_front()};
                    else                  exp_w = '1;
                    check("wdata", bus.wdata, exp_w);
                    check("wstrb", bus.wstrb, 8'hFF);
                    w_cnt++;
                end
                if (hs_b) begin
                    outst--;
                    b_cnt++;
                    if (bus.bresp != 2'b00) model_err++;
                end
                if (char_valid && char_ready) begin
                    exp_q.push_back(char_data);
                    push_cnt++;
                end
                prev_aw_pend = bus.awvalid && !hs_aw;
                prev_w_pend  = bus.wvalid && !hs_w;
                prev_wdata   = bus.wdata;
            end
        end
    end

    initial begin
        int b0, w0, a0, p0, acc, k;
        bit hsc;

        vt[0] = '{ch: 8'h61, resp: 2'd2, e16: 16'd1, e2: 2'd1};
        vt[1] = '{ch: 8'h62, resp: 2'd3, e16: 16'd2, e2: 2'd2};
        vt[2] = '{ch: 8'h63, resp: 2'd0, e16: 16'd2, e2: 2'd2};
        vt[3] = '{ch: 8'h64, resp: 2'd2, e16: 16'd3, e2: 2'd3};
        vt[4] = '{ch: 8'h65, resp: 2'd2, e16: 16'd4, e2: 2'd3};
        vt[5] = '{ch: 8'h66, resp: 2'd2, e16: 16'd5, e2: 2'd3};
        vt[6] = '{ch: 8'h67, resp: 2'd2, e16: 16'd6, e2: 2'd3};
        vt[7] = '{ch: 8'h68, resp: 2'd2, e16: 16'd7, e2: 2'd3};
        vt[8] = '{ch: 8'h6A, resp: 2'd1, e16: 16'd8, e2: 2'd3};
        vt[9] = '{ch: 8'h6B, resp: 2'd0, e16: 16'd8, e2: 2'd3};

        hold_aw = 0; hold_w = 0; rand_ready = 0; rand_resp = 0;
        char_valid = 1'b0; char_data = 8'h00;
        aresetn = 1'b1;
        #2 aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_awvalid", bus.awvalid, 0);
        check("rst_wvalid", bus.wvalid, 0);
        check("rst_bready", bus.bready, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("rst_char_ready", char_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err_count, 0);
        check("rst_arvalid", bus.arvalid, 0);
        check("rst_rready", bus.rready, 0);
        check("rst_awvalid2", bus.awvalid, 0);

        // 'H','i' back to back: latency and B-to-next-AW spacing
        char_valid = 1'b1; char_data = 8'h48;             // cycle N
        @(posedge aclk); #1;
        char_data = 8'h69;                                // N+1
        check("hi_n1_awvalid", bus.awvalid, 0);
        check("hi_n1_busy", busy, 1);
        @(posedge aclk); #1;
        char_valid = 1'b0;                                // N+2
        check("hi_n2_awvalid", bus.awvalid, 1);
        check("hi_n2_wvalid", bus.wvalid, 1);
        check("hi_n2_wdata", bus.wdata, 64'h0101_0000_0000_0048);
        @(posedge aclk); #1;                              // N+3
        check("hi_n3_awvalid", bus.awvalid, 0);
        check("hi_n3_bready", bus.bready, 1);
        @(posedge aclk); #1;                              // N+4
        check("hi_n4_awvalid", bus.awvalid, 0);
        @(posedge aclk); #1;                              // N+5
        check("hi_n5_awvalid", bus.awvalid, 1);
        check("hi_n5_wdata", bus.wdata, 64'h0101_0000_0000_0069);
        wait_b(2, 40);
        repeat (2) @(posedge aclk);
        #1;
        check("hi_busy", busy, 0);
        check("hi_err", err_count, 0);

        // table: one char per record with a scripted response
        for (int i = 0; i < 10; i++) begin
            b0 = b_cnt;
            resp_q.push_back(vt[i].resp);
            char_valid = 1'b1; char_data = vt[i].ch;
            @(posedge aclk); #1;
            char_valid = 1'b0;
            wait_b(b0 + 1, 40);
            repeat (2) @(posedge aclk);
            #1;
            check("vec_err16", err_count, vt[i].e16);
            check("vec_err2", err_count2, vt[i].e2);
            check("vec_busy", busy, 0);
            check_err("vec_model");
        end

        // slave stalled: FIFO fills to FD plus the one in SEND
        hold_aw = 1; hold_w = 1;
        b0 = b_cnt; acc = 0;
        char_valid = 1'b1; char_data = 8'h30;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            hsc = char_ready;
            @(posedge aclk); #1;
            if (hsc) begin
                acc++;
                char_data = char_data + 8'd1;
            end
        end
        char_valid = 1'b0;
        check("full_accepted", acc, FD + 1);
        check("full_char_ready", char_ready, 0);
        check("full_awvalid", bus.awvalid, 1);
        check("full_busy", busy, 1);
        hold_aw = 0; hold_w = 0;
        wait_b(b0 + FD + 1, 400);
        repeat (3) @(posedge aclk);
        #1;
        check("full_drained", exp_q.size(), 0);
        check("full_busy_end", busy, 0);
        check("full_char_ready_end", char_ready, 1);

        // W accepted three cycles before AW
        hold_aw = 1; hold_w = 0;
        b0 = b_cnt; w0 = w_cnt; a0 = aw_cnt;
        char_valid = 1'b1; char_data = 8'h57;
        @(posedge aclk); #1;
        char_valid = 1'b0;
        k = 0;
        while (w_cnt == w0 && k < 30) begin
            @(posedge aclk);
            k++;
        end
        #1;
        check("wfirst_w_seen", w_cnt, w0 + 1);
        check("wfirst_wvalid", bus.wvalid, 0);
        check("wfirst_awvalid", bus.awvalid, 1);
        repeat (2) @(posedge aclk);
        #1;
        check("wfirst_wvalid3", bus.wvalid, 0);
        check("wfirst_awvalid3", bus.awvalid, 1);
        hold_aw = 0;
        wait_b(b0 + 1, 40);
        repeat (10) @(posedge aclk);
        #1;
        check("wfirst_b_once", b_cnt, b0 + 1);
        check("wfirst_aw_once", aw_cnt, a0 + 1);
        check("wfirst_busy", busy, 0);

        // reset mid-SEND with three chars queued behind
        hold_aw = 1; hold_w = 1;
        char_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            char_data = 8'h41 + 8'(i);
            @(posedge aclk); #1;
        end
        char_valid = 1'b0;
        check("rs_awvalid_pre", bus.awvalid, 1);
        a0 = aw_cnt;
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        check("rs_awvalid", bus.awvalid, 0);
        check("rs_wvalid", bus.wvalid, 0);
        check("rs_bready", bus.bready, 0);
        check("rs_busy", busy, 0);
        check("rs_char_ready", char_ready, 1);
        check("rs_err", err_count, 0);
        repeat (3) @(posedge aclk);
        hold_aw = 0; hold_w = 0;
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (20) @(posedge aclk);
        #1;
        check("rs_no_write", aw_cnt, a0);
        check("rs_idle_awvalid", bus.awvalid, 0);
        check("rs_idle_busy", busy, 0);
        b0 = b_cnt;
        char_valid = 1'b1; char_data = 8'h5A;
        @(posedge aclk); #1;
        char_valid = 1'b0;
        wait_b(b0 + 1, 40);
        check("rs_new_write", aw_cnt, a0 + 1);

        // randomized traffic against the reference
        rand_ready = 1; rand_resp = 1;
        b0 = b_cnt; p0 = push_cnt;
        for (int i = 0; i < 800; i++) begin
            @(negedge aclk);
            hsc = char_valid && char_ready;
            @(posedge aclk); #1;
            if (!char_valid || hsc) begin
                char_valid = ($urandom_range(0, 2) != 0);
                char_data  = 8'($urandom);
            end
        end
        char_valid = 1'b0;
        k = 0;
        while (busy && k < 3000) begin
            @(posedge aclk);
            k++;
        end
        repeat (2) @(posedge aclk);
        #1;
        check("rand_idle", busy, 0);
        check("rand_drained", exp_q.size(), 0);
        check("rand_count", b_cnt - b0, push_cnt - p0);
        check("rand_outst", outst, 0);
        check_err("rand");
        check("end_arvalid", bus.arvalid, 0);
        check("end_rready", bus.rready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
